io_port_ctrl: RTL and testbench

IO_PORT_CTRL -- requirements
Module: io_port_ctrl

---
 rtl/io_port_pkg.sv | 43 ++++
 rtl/io_debounce.sv | 41 ++++
 rtl/io_port_ctrl.sv | 146 ++++++++++++++
 tb/tb_io_port_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_port_pkg.sv
// Shared constants and helpers for the 8080 I/O port controller.
package io_port_pkg;

   localparam int unsigned PORT_W     = 8;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned DBNC_CNT_W = 16;
   localparam int unsigned WDOG_CNT_W = 24;

   // IN port map
   localparam logic [PORT_W-1:0] PORT_IN_ID    = 8'd0;
   localparam logic [PORT_W-1:0] PORT_IN_BTN   = 8'd1;
   localparam logic [PORT_W-1:0] PORT_IN_DIP   = 8'd2;
   localparam logic [PORT_W-1:0] PORT_IN_SHIFT = 8'd3;

   // OUT port map
   localparam logic [PORT_W-1:0] PORT_SHIFT_OFS  = 8'd2;
   localparam logic [PORT_W-1:0] PORT_SND1       = 8'd3;
   localparam logic [PORT_W-1:0] PORT_SHIFT_DATA = 8'd4;
   localparam logic [PORT_W-1:0] PORT_SND2       = 8'd5;
   localparam logic [PORT_W-1:0] PORT_WDOG       = 8'd6;

   // Fixed value returned on IN port 0
   localparam logic [DATA_W-1:0] PORT0_VALUE = 8'h0E;

   // One-hot selection of the OUT targets that carry data
   typedef struct packed {
      logic shift_ofs;
      logic shift_data;
      logic snd1;
      logic snd2;
   } out_sel_t;

   function automatic out_sel_t decode_out(input logic [PORT_W-1:0] port);
      out_sel_t sel;
      sel            = '0;
      sel.shift_ofs  = (port == PORT_SHIFT_OFS);
      sel.shift_data = (port == PORT_SHIFT_DATA);
      sel.snd1       = (port == PORT_SND1);
      sel.snd2       = (port == PORT_SND2);
      return sel;
   endfunction

endpackage

// File: rtl/io_debounce.sv
// One-bit 2-FF synchroniser followed by a stability counter.
// The output follows the synchronised input only after DEBOUNCE_CYCLES
// consecutive samples that differ from the current output.
module io_debounce
   import io_port_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_db
);

   logic [1:0]            sync;
   logic [DBNC_CNT_W-1:0] cnt;
   logic                  cnt_done_c;

   // Last sample of the run: the count including this sample reaches the target
   always_comb cnt_done_c = ((17'(cnt) + 17'd1) >= 17'(DEBOUNCE_CYCLES));

   // Synchronise, then count consecutive samples that disagree with the output
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         sync <= 2'b00;
         cnt  <= '0;
         o_db <= 1'b0;
      end else begin
         sync <= {sync[0], i_raw};
         if (sync[1] == o_db) begin
            cnt <= '0;
         end else if (cnt_done_c) begin
            o_db <= sync[1];
            cnt  <= '0;
         end else begin
            cnt <= cnt + DBNC_CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/io_port_ctrl.sv
// 8080 IN/OUT port controller: button/DIP inputs, shifter strobes,
// latched sound ports with rising-edge triggers and an optional watchdog.
// Optional feature macro: IO_WATCHDOG_EN (port-6 kicked watchdog).
module io_port_ctrl
   import io_port_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [23:0] WDOG_CYCLES     = 24'd4000000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_io_req,
   input  logic              i_io_wr,
   input  logic [PORT_W-1:0] i_port,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              o_io_ack,
   output logic [DATA_W-1:0] o_rdata,
   input  logic [7:0]        i_btn,
   input  logic [7:0]        i_dip,
   output logic              o_shift_wr_data,
   output logic              o_shift_wr_offset,
   output logic [DATA_W-1:0] o_shift_wdata,
   input  logic [DATA_W-1:0] i_shift_rdata,
   output logic [DATA_W-1:0] o_snd1,
   output logic [DATA_W-1:0] o_snd2,
   output logic [15:0]       o_snd_trig,
   output logic              o_wdog_rst
);

   logic [7:0]        btn_db;
   logic [7:0]        dip_meta;
   logic [7:0]        dip_sync;
   logic              wr_req_c;
   logic              rd_req_c;
   out_sel_t          out_sel_c;
   logic [DATA_W-1:0] rdata_c;

   // Per-bit button synchroniser and debouncer
   for (genvar b = 0; b < 8; b++) begin : g_btn
      io_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_raw   (i_btn[b]),
         .o_db    (btn_db[b])
      );
   end

   // DIP inputs only need synchronising
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         dip_meta <= 8'h00;
         dip_sync <= 8'h00;
      end else begin
         dip_meta <= i_dip;
         dip_sync <= dip_meta;
      end
   end

   // Request qualification and OUT target decode
   always_comb begin
      wr_req_c  = i_io_req & i_io_wr;
      rd_req_c  = i_io_req & ~i_io_wr;
      out_sel_c = '0;
      if (wr_req_c) begin
         out_sel_c = decode_out(i_port);
      end
   end

   // IN data mux, sampled in the request cycle
   always_comb begin
      rdata_c = 8'h00;
      case (i_port)
         PORT_IN_ID:    rdata_c = PORT0_VALUE;
         PORT_IN_BTN:   rdata_c = btn_db;
         PORT_IN_DIP:   rdata_c = dip_sync;
         PORT_IN_SHIFT: rdata_c = i_shift_rdata;
         default:       rdata_c = 8'h00;
      endcase
   end

   // Ack, read data, shifter strobes and sound latches, all one cycle after req
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_io_ack          <= 1'b0;
         o_rdata           <= 8'h00;
         o_shift_wr_data   <= 1'b0;
         o_shift_wr_offset <= 1'b0;
         o_shift_wdata     <= 8'h00;
         o_snd1            <= 8'h00;
         o_snd2            <= 8'h00;
         o_snd_trig        <= 16'h0000;
      end else begin
         o_io_ack          <= i_io_req;
         o_rdata           <= rd_req_c ? rdata_c : 8'h00;
         o_shift_wr_data   <= out_sel_c.shift_data;
         o_shift_wr_offset <= out_sel_c.shift_ofs;
         if (out_sel_c.shift_data || out_sel_c.shift_ofs) begin
            o_shift_wdata <= i_wdata;
         end
         o_snd_trig <= 16'h0000;
         if (out_sel_c.snd1) begin
            o_snd1           <= i_wdata;
            o_snd_trig[7:0]  <= i_wdata & ~o_snd1;
         end
         if (out_sel_c.snd2) begin
            o_snd2           <= i_wdata;
            o_snd_trig[15:8] <= i_wdata & ~o_snd2;
         end
      end
   end

`ifdef IO_WATCHDOG_EN
   logic [WDOG_CNT_W-1:0] wdog_cnt;
   logic                  kick_c;
   logic                  wdog_done_c;

   // Port-6 write kicks the watchdog; expiry when this cycle completes the count
   always_comb begin
      kick_c      = wr_req_c && (i_port == PORT_WDOG);
      wdog_done_c = ((25'(wdog_cnt) + 25'd1) >= 25'(WDOG_CYCLES));
   end

   // Watchdog counter: a kick always wins over expiry
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wdog_cnt   <= '0;
         o_wdog_rst <= 1'b0;
      end else if (kick_c) begin
         wdog_cnt   <= '0;
         o_wdog_rst <= 1'b0;
      end else if (wdog_done_c) begin
         wdog_cnt   <= '0;
         o_wdog_rst <= 1'b1;
      end else begin
         wdog_cnt   <= wdog_cnt + WDOG_CNT_W'(1);
         o_wdog_rst <= 1'b0;
      end
   end
`else
   // Watchdog absent; the parameter stays on the interface for drop-in builds
   assign o_wdog_rst = 1'b0 & (|WDOG_CYCLES);
`endif

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl (DEBOUNCE_CYCLES=8, WDOG_CYCLES=100).
module tb_io_port_ctrl;

   logic        clk;
   logic        rst_n;
   logic        io_req;
   logic        io_wr;
   logic [7:0]  port;
   logic [7:0]  wdata;
   logic        io_ack;
   logic [7:0]  rdata;
   logic [7:0]  btn;
   logic [7:0]  dip;
   logic        shift_wr_data;
   logic        shift_wr_offset;
   logic [7:0]  shift_wdata;
   logic [7:0]  shift_rdata;
   logic [7:0]  snd1;
   logic [7:0]  snd2;
   logic [15:0] snd_trig;
   logic        wdog_rst;

   int tests;
   int failed;

   io_port_ctrl #(
      .DEBOUNCE_CYCLES (16'd8),
      .WDOG_CYCLES     (24'd100)
   ) dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_io_req          (io_req),
      .i_io_wr           (io_wr),
      .i_port            (port),
      .i_wdata           (wdata),
      .o_io_ack          (io_ack),
      .o_rdata           (rdata),
      .i_btn             (btn),
      .i_dip             (dip),
      .o_shift_wr_data   (shift_wr_data),
      .o_shift_wr_offset (shift_wr_offset),
      .o_shift_wdata     (shift_wdata),
      .i_shift_rdata     (shift_rdata),
      .o_snd1            (snd1),
      .o_snd2            (snd2),
      .o_snd_trig        (snd_trig),
      .o_wdog_rst        (wdog_rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of bus inputs, then sample 1 time unit after the edge
   task automatic step(input logic req, input logic wr, input logic [7:0] p, input logic [7:0] wd);
      io_req = req;
      io_wr  = wr;
      port   = p;
      wdata  = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
   endtask

   // Reference state for the randomized section
   logic [7:0]  m_snd1, m_snd2, m_swd, m_btn, m_dip;
   logic [7:0]  e_rdata;
   logic [15:0] e_trig;
   logic        e_ofs, e_dat;
   logic        r_req, r_wr;
   logic [7:0]  r_port, r_wd;
   int          first_pulse, pulses;

   initial begin
      tests = 0; failed = 0;
      io_req = 0; io_wr = 0; port = 0; wdata = 0;
      btn = 8'h00; dip = 8'h00; shift_rdata = 8'h00;
      rst_n = 1'b0;
      idle(3);

      // Reset state
      check("rst_ack", 32'(io_ack), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_strobes", 32'({shift_wr_data, shift_wr_offset}), 32'd0);
      check("rst_swdata", 32'(shift_wdata), 32'd0);
      check("rst_snd", 32'({snd2, snd1}), 32'd0);
      check("rst_trig", 32'(snd_trig), 32'd0);
      check("rst_wdog", 32'(wdog_rst), 32'd0);
      rst_n = 1'b1;
      idle(2);

      // Shifter strobes
      step(1, 1, 8'd4, 8'hAA);
      check("sh1_ack", 32'(io_ack), 32'd1);
      check("sh1_strb", 32'({shift_wr_data, shift_wr_offset}), 32'b10);
      check("sh1_wd", 32'(shift_wdata), 32'hAA);
      step(1, 1, 8'd4, 8'hFF);
      check("sh2_strb", 32'({shift_wr_data, shift_wr_offset}), 32'b10);
      check("sh2_wd", 32'(shift_wdata), 32'hFF);
      step(1, 1, 8'd2, 8'h04);
      check("sh3_strb", 32'({shift_wr_data, shift_wr_offset}), 32'b01);
      check("sh3_wd", 32'(shift_wdata), 32'h04);
      step(0, 0, 8'd0, 8'h00);
      check("sh_idle_strb", 32'({shift_wr_data, shift_wr_offset}), 32'b00);
      check("sh_idle_hold", 32'(shift_wdata), 32'h04);
      check("sh_idle_ack", 32'(io_ack), 32'd0);

      // Shifter read and unmapped port
      shift_rdata = 8'h5C;
      step(1, 0, 8'd3, 8'h00);
      shift_rdata = 8'h00;
      check("in3_ack", 32'(io_ack), 32'd1);
      check("in3_data", 32'(rdata), 32'h5C);
      step(1, 0, 8'd7, 8'h00);
      check("in7_ack", 32'(io_ack), 32'd1);
      check("in7_data", 32'(rdata), 32'h00);
      step(1, 0, 8'd0, 8'h00);
      check("in0_data", 32'(rdata), 32'h0E);

      // Sound triggers
      step(1, 1, 8'd3, 8'h01);
      check("snd_a_trig", 32'(snd_trig), 32'h0001);
      step(1, 1, 8'd3, 8'h03);
      check("snd_b_trig", 32'(snd_trig), 32'h0002);
      step(1, 1, 8'd3, 8'h03);
      check("snd_c_trig", 32'(snd_trig), 32'h0000);
      check("snd_c_val", 32'(snd1), 32'h03);
      step(0, 0, 8'd0, 8'h00);
      check("snd_idle_trig", 32'(snd_trig), 32'h0000);

      // DIP synchroniser
      dip = 8'hA5;
      idle(3);
      step(1, 0, 8'd2, 8'h00);
      check("dip_data", 32'(rdata), 32'hA5);

      // Button glitch rejected, long hold accepted
      btn = 8'h10;
      idle(5);
      btn = 8'h00;
      idle(14);
      step(1, 0, 8'd1, 8'h00);
      check("btn_glitch", 32'(rdata), 32'h00);
      btn = 8'h10;
      idle(12);
      step(1, 0, 8'd1, 8'h00);
      check("btn_held", 32'(rdata), 32'h10);

`ifdef IO_WATCHDOG_EN
      // Expiry without kicks
      do_reset();
      first_pulse = 0; pulses = 0;
      for (int n = 1; n <= 150; n++) begin
         step(0, 0, 8'd0, 8'h00);
         if (wdog_rst) begin
            pulses++;
            if (first_pulse == 0) first_pulse = n;
         end
      end
      check("wdog_first", 32'(first_pulse), 32'd100);
      check("wdog_count", 32'(pulses), 32'd1);
      // Regular kicks keep it quiet
      do_reset();
      pulses = 0;
      for (int n = 1; n <= 300; n++) begin
         if (n % 50 == 0) step(1, 1, 8'd6, 8'h00);
         else             step(0, 0, 8'd0, 8'h00);
         if (wdog_rst) pulses++;
      end
      check("wdog_kicked", 32'(pulses), 32'd0);
`else
      do_reset();
      pulses = 0;
      for (int n = 1; n <= 150; n++) begin
         step(0, 0, 8'd0, 8'h00);
         if (wdog_rst) pulses++;
      end
      check("wdog_off", 32'(pulses), 32'd0);
`endif
      step(1, 1, 8'd6, 8'h00);
      check("p6_ack", 32'(io_ack), 32'd1);

      // Reset in the middle of back-to-back traffic
      idle(14);
      step(1, 0, 8'd1, 8'h00);
      check("b2b_in1", 32'(rdata), 32'h10);
      step(1, 1, 8'd5, 8'h81);
      check("b2b_snd2", 32'(snd2), 32'h81);
      check("b2b_trig", 32'(snd_trig), 32'h8100);
      rst_n = 1'b0;
      step(1, 0, 8'd2, 8'h00);
      check("mid_rst_ack", 32'(io_ack), 32'd0);
      check("mid_rst_rdata", 32'(rdata), 32'd0);
      check("mid_rst_snd2", 32'(snd2), 32'd0);
      check("mid_rst_trig", 32'(snd_trig), 32'd0);
      rst_n = 1'b1;
      step(0, 0, 8'd0, 8'h00);
      check("post_rst_ack", 32'(io_ack), 32'd0);
      step(1, 0, 8'd1, 8'h00);
      check("post_rst_btn", 32'(rdata), 32'h00);

      // Randomized traffic against the reference model
      m_btn = 8'($urandom);
      m_dip = 8'($urandom);
      btn = m_btn;
      dip = m_dip;
      do_reset();
      idle(16);
      m_snd1 = 8'h00; m_snd2 = 8'h00; m_swd = 8'h00;
      for (int k = 0; k < 60; k++) begin
         r_req  = ($urandom_range(0, 3) != 0);
         r_wr   = 1'($urandom_range(0, 1));
         r_port = 8'($urandom_range(0, 9));
         r_wd   = 8'($urandom);
         shift_rdata = 8'($urandom);
         e_rdata = 8'h00; e_trig = 16'h0000; e_ofs = 1'b0; e_dat = 1'b0;
         if (r_req && !r_wr) begin
            if (r_port == 8'd0)      e_rdata = 8'h0E;
            else if (r_port == 8'd1) e_rdata = m_btn;
            else if (r_port == 8'd2) e_rdata = m_dip;
            else if (r_port == 8'd3) e_rdata = shift_rdata;
         end
         if (r_req && r_wr) begin
            if (r_port == 8'd2) begin e_ofs = 1'b1; m_swd = r_wd; end
            if (r_port == 8'd4) begin e_dat = 1'b1; m_swd = r_wd; end
            if (r_port == 8'd3) begin e_trig[7:0]  = r_wd & ~m_snd1; m_snd1 = r_wd; end
            if (r_port == 8'd5) begin e_trig[15:8] = r_wd & ~m_snd2; m_snd2 = r_wd; end
         end
         step(r_req, r_wr, r_port, r_wd);
         check("rnd_ack", 32'(io_ack), 32'(r_req));
         check("rnd_rdata", 32'(rdata), 32'(e_rdata));
         check("rnd_strb", 32'({shift_wr_data, shift_wr_offset}), 32'({e_dat, e_ofs}));
         check("rnd_swd", 32'(shift_wdata), 32'(m_swd));
         check("rnd_snd", 32'({snd2, snd1}), 32'({m_snd2, m_snd1}));
         check("rnd_trig", 32'(snd_trig), 32'(e_trig));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
